// File: rtl/apple1_kbd_port_pkg.sv
// Shared definitions for the Apple-1 keyboard port: FSM states, default timing and
// the ASCII constants used by the case folder.
package apple1_kbd_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } kbd_state_t;

    localparam int DEF_DEPTH         = 8;
    localparam int DEF_SETUP_CYCLES  = 5;
    localparam int DEF_STROBE_CYCLES = 50;
    localparam int DEF_GAP_CYCLES    = 50000;

    localparam int         ASCII_W        = 7;
    localparam logic [6:0] ASCII_LC_A     = 7'h61;
    localparam logic [6:0] ASCII_LC_Z     = 7'h7A;
    localparam int         ASCII_CASE_BIT = 5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [6:0] upcase(input logic [6:0] c);
        logic [6:0] r;
        r = c;
        if (c >= ASCII_LC_A && c <= ASCII_LC_Z) begin
            r[ASCII_CASE_BIT] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/apple1_kbd_port_fifo.sv
// Small register FIFO for keyboard codes; a push is accepted when full if a pop
// happens in the same cycle.
module apple1_kbd_port_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apple1_kbd_port.sv
// Apple-1 keyboard port: buffers PS/2 ASCII codes, folds case, and presents them to
// the 6821 PIA port A with a paced CA1 strobe.
module apple1_kbd_port
    import apple1_kbd_port_pkg::*;
#(
    parameter int DEPTH         = DEF_DEPTH,
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int USE_ACK       = 1,
    parameter int UPCASE        = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ASCII_W-1:0] ascii_code,
    input  logic               ascii_new,
    input  logic               kbd_rd,
    output logic [ASCII_W-1:0] pia_data,
    output logic               pia_strobe,
    output logic               fifo_full,
    output logic               overflow
);
    localparam int CNT_MAX = max3(SETUP_CYCLES, STROBE_CYCLES, GAP_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

    kbd_state_t         state;
    kbd_state_t         state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [ASCII_W-1:0] data_n;
    logic               strobe_n;
    logic [ASCII_W-1:0] code_in;
    logic [ASCII_W-1:0] head;
    logic               full;
    logic               empty;
    logic               pop;
    logic               rd_s1;
    logic               rd_s2;
    logic               rd_s3;
    logic               ack;

    assign code_in = (UPCASE != 0) ? upcase(ascii_code) : ascii_code;

    apple1_kbd_port_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ASCII_W)
    ) u_kbd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ascii_new),
        .pop   (pop),
        .din   (code_in),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign fifo_full = full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (ascii_new && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // kbd_rd comes straight from the CPU bus decode, so it is synchronised first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_s1 <= 1'b0;
            rd_s2 <= 1'b0;
            rd_s3 <= 1'b0;
        end else begin
            rd_s1 <= kbd_rd;
            rd_s2 <= rd_s1;
            rd_s3 <= rd_s2;
        end
    end

    assign ack = rd_s2 && !rd_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            pia_data   <= '0;
            pia_strobe <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pia_data   <= data_n;
            pia_strobe <= strobe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        data_n  = pia_data;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    data_n  = head;
                    cnt_n   = '0;
                    state_n = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_STROBE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt == STROBE_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_HOLD;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (((USE_ACK != 0) && ack) || cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
        // Registered strobe: high exactly for the cycles spent in STROBE.
        strobe_n = (state_n == ST_STROBE);
    end

endmodule
